// File: rtl/pcie_cfg_responder.sv
// Purpose: completer for PCIe Type-0/Type-1 CfgRd/CfgWr TLPs, served from a local register file.
// Latency: request accepted in cycle N -> completion valid in cycle N+2 (single-beat requests).
// Backpressure: RX is held off (tready=0) while decoding and until the completion handshakes.
//
// Ports:
//   pclk_div2 / apb_rst       clock, synchronous active-high reset
//   completer_id              bus/dev/func reported in completions
//   axis_master_*             RX AXI-Stream carrying request TLPs (128-bit, DW0 in [31:0])
//   axis_slave_*              TX AXI-Stream carrying single-beat Cpl/CplD TLPs
//   cfg_regs_flat             register file contents, reg i at [32i+31:32i]
//   ur_cnt / drop_cnt         saturating counts of UR completions / discarded non-config TLPs
// Build option: define CFG_RESP_CRS_EN to add input cfg_not_ready; while it is high, valid
//   requests complete with CRS status and no register write.
module pcie_cfg_responder #(
  parameter int          REG_NUM  = 16,
  parameter logic [31:0] ID_VALUE = 32'h0000_0755
) (
  input  logic                   pclk_div2,
  input  logic                   apb_rst,
  input  logic [15:0]            completer_id,
`ifdef CFG_RESP_CRS_EN
  input  logic                   cfg_not_ready,
`endif
  input  logic                   axis_master_tvalid,
  output logic                   axis_master_tready,
  input  logic                   axis_master_tlast,
  input  logic [3:0]             axis_master_tkeep,
  input  logic [127:0]           axis_master_tdata,
  output logic                   axis_slave_tvalid,
  input  logic                   axis_slave_tready,
  output logic                   axis_slave_tlast,
  output logic                   axis_slave_tuser,
  output logic [127:0]           axis_slave_tdata,
  output logic [REG_NUM*32-1:0]  cfg_regs_flat,
  output logic [15:0]            ur_cnt,
  output logic [15:0]            drop_cnt
);

  localparam int          IW      = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
  localparam logic [10:0] REG_LIM = 11'(REG_NUM);

  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_CPL, S_DRAIN} state_t;

  state_t       state, state_nxt, drain_next;
  logic         rx_rdy;
  logic [31:0]  dw0, dw1, dw2, dw3;
  logic [31:0]  regs [REG_NUM];
  logic [127:0] cpl_q;

  // Config = Type-0/Type-1 with a 3DW no-data (read) or 3DW with-data (write) format.
  logic in_is_cfg;
  assign in_is_cfg = ((axis_master_tdata[28:24] == 5'b00100) || (axis_master_tdata[28:24] == 5'b00101)) &&
                     ((axis_master_tdata[30:29] == 2'b00) || (axis_master_tdata[30:29] == 2'b10));

  // Decode of the captured request; only consumed while in S_DECODE.
  logic        d_wr, d_ur, d_crs, d_has_data, d_write;
  logic [9:0]  d_idx;
  logic [2:0]  d_status;
  logic [31:0] d_rd_data, d_cpl_dw0, d_cpl_dw1, d_cpl_dw2;

  assign d_wr  = (dw0[30:29] == 2'b10);
  assign d_idx = {dw2[11:8], dw2[7:2]};
  assign d_ur  = (dw0[28:24] == 5'b00101) || (dw0[9:0] != 10'd1) || dw0[14] ||
                 (dw1[7:4] != 4'd0) || ({1'b0, d_idx} >= REG_LIM);
`ifdef CFG_RESP_CRS_EN
  assign d_crs = cfg_not_ready && !d_ur;
`else
  assign d_crs = 1'b0;
`endif
  assign d_status   = d_ur ? 3'b001 : (d_crs ? 3'b010 : 3'b000);
  assign d_has_data = !d_wr && !d_ur && !d_crs;
  // Register 0 is the read-only ID; it is loaded at reset and never written.
  assign d_write    = (state == S_DECODE) && d_wr && !d_ur && !d_crs && (d_idx != 10'd0);
  assign d_rd_data  = regs[d_idx[IW-1:0]];

  assign d_cpl_dw0 = {(d_has_data ? 3'b010 : 3'b000), 5'b01010, 1'b0, dw0[22:20], 4'b0000,
                      2'b00, dw0[13:12], 2'b00, (d_has_data ? 10'd1 : 10'd0)};
  assign d_cpl_dw1 = {completer_id, d_status, 1'b0, 12'd4};
  assign d_cpl_dw2 = {dw1[31:16], dw1[15:8], 1'b0, 7'd0};

  always_ff @(posedge pclk_div2) begin
    if (apb_rst) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt         = state;
    rx_rdy            = 1'b0;
    axis_slave_tvalid = 1'b0;
    case (state)
      S_IDLE: begin
        rx_rdy = 1'b1;
        if (axis_master_tvalid) begin
          if (in_is_cfg) state_nxt = axis_master_tlast ? S_DECODE : S_DRAIN;
          else           state_nxt = axis_master_tlast ? S_IDLE   : S_DRAIN;
        end
      end
      S_DECODE: state_nxt = S_CPL;
      S_CPL: begin
        axis_slave_tvalid = 1'b1;
        if (axis_slave_tready) state_nxt = S_IDLE;
      end
      S_DRAIN: begin
        rx_rdy = 1'b1;
        if (axis_master_tvalid && axis_master_tlast) state_nxt = drain_next;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign axis_master_tready = rx_rdy && !apb_rst;
  assign axis_slave_tlast   = axis_slave_tvalid;
  assign axis_slave_tuser   = 1'b0;
  assign axis_slave_tdata   = cpl_q;

  always_ff @(posedge pclk_div2) begin
    if (apb_rst) begin
      dw0        <= '0;
      dw1        <= '0;
      dw2        <= '0;
      dw3        <= '0;
      drain_next <= S_IDLE;
      cpl_q      <= '0;
      ur_cnt     <= '0;
      drop_cnt   <= '0;
      for (int i = 0; i < REG_NUM; i++) regs[i] <= (i == 0) ? ID_VALUE : 32'd0;
    end else begin
      if (state == S_IDLE && axis_master_tvalid) begin
        dw0        <= axis_master_tdata[31:0];
        dw1        <= axis_master_tdata[63:32];
        dw2        <= axis_master_tdata[95:64];
        dw3        <= axis_master_tdata[127:96];
        drain_next <= in_is_cfg ? S_DECODE : S_IDLE;
        if (!in_is_cfg && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end
      if (state == S_DECODE) begin
        cpl_q <= {(d_has_data ? d_rd_data : 32'd0), d_cpl_dw2, d_cpl_dw1, d_cpl_dw0};
        if (d_ur && ur_cnt != 16'hFFFF) ur_cnt <= ur_cnt + 16'd1;
      end
      if (d_write) begin
        for (int k = 0; k < 4; k++)
          if (dw1[k]) regs[d_idx[IW-1:0]][8*k +: 8] <= dw3[8*k +: 8];
      end
    end
  end

  for (genvar g = 0; g < REG_NUM; g++) begin : g_flat
    assign cfg_regs_flat[32*g +: 32] = regs[g];
  end

  // Fields carried but not interpreted by this completer.
  logic unused_bits;
  assign unused_bits = ^{axis_master_tkeep, dw0, dw2};

endmodule

// File: tb/tb_pcie_cfg_responder.sv
module tb_pcie_cfg_responder;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   cid;
  logic          m_tvalid, m_tready, m_tlast;
  logic [3:0]    m_tkeep;
  logic [127:0]  m_tdata;
  logic          s_tvalid, s_tready, s_tlast, s_tuser;
  logic [127:0]  s_tdata;
  logic [511:0]  regs_flat;
  logic [15:0]   ur_cnt, drop_cnt;
`ifdef CFG_RESP_CRS_EN
  logic          not_rdy;
`endif

  int tests_run = 0;
  int failures  = 0;

  always #5 clk = ~clk;

  pcie_cfg_responder #(.REG_NUM(16), .ID_VALUE(32'h0000_0755)) dut (
    .pclk_div2          (clk),
    .apb_rst            (rst),
    .completer_id       (cid),
`ifdef CFG_RESP_CRS_EN
    .cfg_not_ready      (not_rdy),
`endif
    .axis_master_tvalid (m_tvalid),
    .axis_master_tready (m_tready),
    .axis_master_tlast  (m_tlast),
    .axis_master_tkeep  (m_tkeep),
    .axis_master_tdata  (m_tdata),
    .axis_slave_tvalid  (s_tvalid),
    .axis_slave_tready  (s_tready),
    .axis_slave_tlast   (s_tlast),
    .axis_slave_tuser   (s_tuser),
    .axis_slave_tdata   (s_tdata),
    .cfg_regs_flat      (regs_flat),
    .ur_cnt             (ur_cnt),
    .drop_cnt           (drop_cnt)
  );

  // Request TLP, requester id 16'h0100: {DW3 data, DW2 address, DW1 id/tag/BE, DW0 header}.
  function automatic logic [127:0] cfg_req(input logic wr, input logic t1, input logic [9:0] len,
                                           input logic [3:0] lbe, input logic [3:0] fbe,
                                           input logic [7:0] tag, input logic [9:0] idx,
                                           input logic [31:0] data);
    logic [31:0] d0, d1, d2;
    d0 = {1'b0, wr, 1'b0, 4'b0010, t1, 14'd0, len};
    d1 = {16'h0100, tag, lbe, fbe};
    d2 = {16'h0000, 4'd0, idx[9:6], idx[5:0], 2'b00};
    return {data, d2, d1, d0};
  endfunction

  // Present one RX beat; returns one cycle after the accepting edge (+1).
  task automatic send(input logic [127:0] d, input logic last);
    bit ok;
    ok = 0;
    m_tdata = d; m_tlast = last; m_tvalid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (m_tready) ok = 1;
      @(posedge clk); #1;
    end
    m_tvalid = 1'b0; m_tlast = 1'b0;
    tests_run++;
    if (!ok) begin failures++; $display("FAIL send_accept: tready never seen, required 1"); end
  endtask

  // Waits for a completion (s_tready must be 1), returns it and the cycles waited, then handshakes.
  task automatic get_cpl(output logic [127:0] d, output int lat);
    bit ok;
    ok = 0; lat = 0; d = '0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (s_tvalid) begin d = s_tdata; ok = 1; end
      else begin @(posedge clk); #1; lat++; end
    end
    tests_run++;
    if (!ok) begin failures++; $display("FAIL cpl_timeout: no tvalid in 20 cycles, required completion"); end
    else begin @(posedge clk); #1; end
  endtask

  task automatic test_reset;
    rst = 1'b1; cid = 16'h0200; m_tvalid = 0; m_tlast = 0; m_tkeep = 4'hF; m_tdata = '0; s_tready = 1'b1;
`ifdef CFG_RESP_CRS_EN
    not_rdy = 1'b0;
`endif
    @(posedge clk); @(posedge clk); #1;
    tests_run++;
    if (m_tready !== 1'b0) begin failures++; $display("FAIL reset_rx_ready: got %b required 0", m_tready); end
    tests_run++;
    if (s_tvalid !== 1'b0 || s_tdata !== 128'd0) begin failures++; $display("FAIL reset_tx: got vld %b dat %h required 0/0", s_tvalid, s_tdata); end
    tests_run++;
    if (ur_cnt !== 16'd0 || drop_cnt !== 16'd0) begin failures++; $display("FAIL reset_cnt: got ur %h drop %h required 0/0", ur_cnt, drop_cnt); end
    tests_run++;
    if (regs_flat !== {480'd0, 32'h0000_0755}) begin failures++; $display("FAIL reset_regs: got %h", regs_flat); end
    rst = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if (m_tready !== 1'b1) begin failures++; $display("FAIL idle_rx_ready: got %b required 1", m_tready); end
  endtask

  task automatic test_read_id;
    logic [127:0] c, r;
    int lat;
    send(cfg_req(1'b0, 1'b0, 10'd1, 4'h0, 4'hF, 8'h12, 10'd0, 32'd0), 1'b1);
    tests_run++;
    if (s_tvalid !== 1'b0) begin failures++; $display("FAIL decode_no_valid: got %b required 0", s_tvalid); end
    get_cpl(c, lat);
    // Accept at N, DECODE at N+1, tvalid at N+2: one edge after the return of send.
    tests_run++;
    if (lat !== 1) begin failures++; $display("FAIL read_latency: got %0d required 1", lat); end
    tests_run++;
    if (c !== {32'h0000_0755, 32'h0100_1200, 32'h0200_0004, 32'h4A00_0001}) begin
      failures++; $display("FAIL read_id_cpl: got %h required %h", c, {32'h0000_0755, 32'h0100_1200, 32'h0200_0004, 32'h4A00_0001});
    end
    // TC copied into the completion.
    r = cfg_req(1'b0, 1'b0, 10'd1, 4'h0, 4'hF, 8'h13, 10'd0, 32'd0);
    r[22:20] = 3'd3;
    send(r, 1'b1);
    get_cpl(c, lat);
    tests_run++;
    if (c[31:0] !== 32'h4A30_0001) begin failures++; $display("FAIL tc_copy: got %h required 4a300001", c[31:0]); end
  endtask

  task automatic test_write_read;
    logic [127:0] c;
    int lat;
    send(cfg_req(1'b1, 1'b0, 10'd1, 4'h0, 4'b0101, 8'h21, 10'd3, 32'hAABB_CCDD), 1'b1);
    get_cpl(c, lat);
    tests_run++;
    if (c !== {32'h0, 32'h0100_2100, 32'h0200_0004, 32'h0A00_0000}) begin
      failures++; $display("FAIL write_cpl: got %h required %h", c, {32'h0, 32'h0100_2100, 32'h0200_0004, 32'h0A00_0000});
    end
    tests_run++;
    if (regs_flat[3*32 +: 32] !== 32'h00BB_00DD) begin failures++; $display("FAIL write_reg3: got %h required 00bb00dd", regs_flat[3*32 +: 32]); end
    send(cfg_req(1'b0, 1'b0, 10'd1, 4'h0, 4'hF, 8'h22, 10'd3, 32'd0), 1'b1);
    get_cpl(c, lat);
    tests_run++;
    if (c !== {32'h00BB_00DD, 32'h0100_2200, 32'h0200_0004, 32'h4A00_0001}) begin
      failures++; $display("FAIL read_reg3: got %h required %h", c, {32'h00BB_00DD, 32'h0100_2200, 32'h0200_0004, 32'h4A00_0001});
    end
    // Write to the ID register completes SC but has no effect.
    send(cfg_req(1'b1, 1'b0, 10'd1, 4'h0, 4'hF, 8'h23, 10'd0, 32'hFFFF_FFFF), 1'b1);
    get_cpl(c, lat);
    tests_run++;
    if (c[63:32] !== 32'h0200_0004 || regs_flat[31:0] !== 32'h0000_0755) begin
      failures++; $display("FAIL write_reg0: got dw1 %h reg0 %h required 02000004/00000755", c[63:32], regs_flat[31:0]);
    end
  endtask

  task automatic test_ur;
    logic [127:0] c;
    int lat;
    send(cfg_req(1'b0, 1'b0, 10'd1, 4'h0, 4'hF, 8'h30, 10'd20, 32'd0), 1'b1);
    get_cpl(c, lat);
    tests_run++;
    if (c !== {32'h0, 32'h0100_3000, 32'h0200_2004, 32'h0A00_0000}) begin
      failures++; $display("FAIL ur_index: got %h required %h", c, {32'h0, 32'h0100_3000, 32'h0200_2004, 32'h0A00_0000});
    end
    send(cfg_req(1'b0, 1'b1, 10'd1, 4'h0, 4'hF, 8'h31, 10'd1, 32'd0), 1'b1);
    get_cpl(c, lat);
    tests_run++;
    if (c !== {32'h0, 32'h0100_3100, 32'h0200_2004, 32'h0A00_0000}) begin
      failures++; $display("FAIL ur_type1: got %h required %h", c, {32'h0, 32'h0100_3100, 32'h0200_2004, 32'h0A00_0000});
    end
    tests_run++;
    if (ur_cnt !== 16'd2) begin failures++; $display("FAIL ur_cnt_2: got %0d required 2", ur_cnt); end
    // Length 2 write: UR, register untouched.
    send(cfg_req(1'b1, 1'b0, 10'd2, 4'h0, 4'hF, 8'h32, 10'd4, 32'h1234_5678), 1'b1);
    get_cpl(c, lat);
    tests_run++;
    if (c[63:32] !== 32'h0200_2004 || regs_flat[4*32 +: 32] !== 32'd0 || ur_cnt !== 16'd3) begin
      failures++; $display("FAIL ur_len: got dw1 %h reg4 %h ur %0d required 02002004/0/3", c[63:32], regs_flat[4*32 +: 32], ur_cnt);
    end
  endtask

  task automatic test_backpressure;
    logic [127:0] c, held;
    int lat;
    bit ok;
    s_tready = 1'b0;
    send(cfg_req(1'b0, 1'b0, 10'd1, 4'h0, 4'hF, 8'h40, 10'd3, 32'd0), 1'b1);
    @(posedge clk); #1;
    held = s_tdata;
    tests_run++;
    if (s_tvalid !== 1'b1 || held !== {32'h00BB_00DD, 32'h0100_4000, 32'h0200_0004, 32'h4A00_0001}) begin
      failures++; $display("FAIL bp_first: got vld %b dat %h", s_tvalid, held);
    end
    // A waiting request must not be accepted while the completion is held.
    m_tdata = cfg_req(1'b0, 1'b0, 10'd1, 4'h0, 4'hF, 8'h44, 10'd0, 32'd0); m_tlast = 1'b1; m_tvalid = 1'b1;
    ok = 1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (s_tvalid !== 1'b1 || s_tdata !== held || m_tready !== 1'b0 || s_tlast !== 1'b1 || s_tuser !== 1'b0) ok = 0;
    end
    tests_run++;
    if (!ok) begin failures++; $display("FAIL bp_hold: tx vld %b dat %h rx rdy %b, required 1/held/0", s_tvalid, s_tdata, m_tready); end
    s_tready = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (s_tvalid !== 1'b0 || m_tready !== 1'b1) begin failures++; $display("FAIL bp_release: got tx vld %b rx rdy %b required 0/1", s_tvalid, m_tready); end
    @(posedge clk); #1;
    m_tvalid = 1'b0; m_tlast = 1'b0;
    get_cpl(c, lat);
    tests_run++;
    if (c !== {32'h0000_0755, 32'h0100_4400, 32'h0200_0004, 32'h4A00_0001}) begin
      failures++; $display("FAIL bp_next_req: got %h", c);
    end
  endtask

  task automatic test_drop;
    logic [127:0] c;
    int lat;
    send({32'h1111_1111, 32'h2000_0000, 32'h0100_500F, 32'h4000_0001}, 1'b0);
    send({128{1'b1}}, 1'b1);
    tests_run++;
    if (drop_cnt !== 16'd1 || s_tvalid !== 1'b0) begin failures++; $display("FAIL drop_mwr: got drop %0d vld %b required 1/0", drop_cnt, s_tvalid); end
    send(cfg_req(1'b0, 1'b0, 10'd1, 4'h0, 4'hF, 8'h51, 10'd0, 32'd0), 1'b1);
    get_cpl(c, lat);
    tests_run++;
    if (c !== {32'h0000_0755, 32'h0100_5100, 32'h0200_0004, 32'h4A00_0001} || lat !== 1) begin
      failures++; $display("FAIL drop_then_read: got %h lat %0d", c, lat);
    end
    // Config request spanning two beats: trailing beat drained, then answered.
    send(cfg_req(1'b0, 1'b0, 10'd1, 4'h0, 4'hF, 8'h55, 10'd3, 32'd0), 1'b0);
    send({128{1'b1}}, 1'b1);
    get_cpl(c, lat);
    tests_run++;
    if (c !== {32'h00BB_00DD, 32'h0100_5500, 32'h0200_0004, 32'h4A00_0001} || drop_cnt !== 16'd1) begin
      failures++; $display("FAIL cfg_two_beat: got %h drop %0d", c, drop_cnt);
    end
  endtask

`ifdef CFG_RESP_CRS_EN
  task automatic test_crs;
    logic [127:0] c;
    int lat;
    not_rdy = 1'b1;
    send(cfg_req(1'b1, 1'b0, 10'd1, 4'h0, 4'hF, 8'h60, 10'd2, 32'h1234_5678), 1'b1);
    get_cpl(c, lat);
    not_rdy = 1'b0;
    tests_run++;
    if (c !== {32'h0, 32'h0100_6000, 32'h0200_4004, 32'h0A00_0000}) begin failures++; $display("FAIL crs_cpl: got %h", c); end
    tests_run++;
    if (regs_flat[2*32 +: 32] !== 32'd0 || ur_cnt !== 16'd3) begin
      failures++; $display("FAIL crs_side_effects: got reg2 %h ur %0d required 0/3", regs_flat[2*32 +: 32], ur_cnt);
    end
  endtask
`endif

  task automatic test_reset_mid_cpl;
    s_tready = 1'b0;
    send(cfg_req(1'b0, 1'b0, 10'd1, 4'h0, 4'hF, 8'h70, 10'd3, 32'd0), 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (s_tvalid !== 1'b0 || s_tdata !== 128'd0) begin failures++; $display("FAIL rst_mid_cpl: got vld %b dat %h required 0/0", s_tvalid, s_tdata); end
    rst = 1'b0; s_tready = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (m_tready !== 1'b1 || s_tvalid !== 1'b0 || regs_flat[3*32 +: 32] !== 32'd0 || ur_cnt !== 16'd0 || drop_cnt !== 16'd0) begin
      failures++; $display("FAIL rst_mid_cpl_idle: got rdy %b vld %b reg3 %h ur %0d drop %0d", m_tready, s_tvalid, regs_flat[3*32 +: 32], ur_cnt, drop_cnt);
    end
  endtask

  initial begin
    test_reset;
    test_read_id;
    test_write_read;
    test_ur;
    test_backpressure;
    test_drop;
`ifdef CFG_RESP_CRS_EN
    test_crs;
`endif
    test_reset_mid_cpl;
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
